// File: rtl/led_blink_pio_pkg.sv
// Register map and status bit positions for the LED blink PIO.
package led_blink_pio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_OUTTOG   = 3'd6;

  localparam int STATUS_PHASE_BIT     = 0;
  localparam int STATUS_PERIOD_NZ_BIT = 1;

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink prescaler: reloading down-counter that toggles phase on each expiry.
module led_blink_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  restart,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] cnt;

  // restart outranks expiry so a PERIOD write never adds a stray toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= period;
      phase <= 1'b1;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/led_blink_pio.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle and per-bit blinking.
module led_blink_pio
  import led_blink_pio_pkg::*;
#(
  parameter int          WIDTH       = 18,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PRESCALE_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic                  wr_en;
  logic [31:0]           lane_mask;
  logic [31:0]           wmasked;
  logic [WIDTH-1:0]      data_q, data_nxt;
  logic [WIDTH-1:0]      blink_q, blink_nxt;
  logic [PRESCALE_W-1:0] period_q, period_nxt;
  logic                  period_restart;
  logic                  phase;

  assign wr_en     = chipselect & ~write_n;
  assign lane_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                      {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign wmasked   = writedata & lane_mask;

  assign period_restart = wr_en && (address == ADDR_PERIOD) && (|byteenable);

  always_comb begin
    data_nxt   = data_q;
    blink_nxt  = blink_q;
    period_nxt = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_nxt   = (data_q & ~lane_mask[WIDTH-1:0]) | wmasked[WIDTH-1:0];
        ADDR_BLINK_EN: blink_nxt  = (blink_q & ~lane_mask[WIDTH-1:0]) | wmasked[WIDTH-1:0];
        ADDR_PERIOD:   period_nxt = (period_q & ~lane_mask[PRESCALE_W-1:0])
                                    | wmasked[PRESCALE_W-1:0];
        ADDR_OUTSET:   data_nxt   = data_q | wmasked[WIDTH-1:0];
        ADDR_OUTCLR:   data_nxt   = data_q & ~wmasked[WIDTH-1:0];
        ADDR_OUTTOG:   data_nxt   = data_q ^ wmasked[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE[WIDTH-1:0];
      blink_q  <= '0;
      period_q <= '0;
    end else begin
      data_q   <= data_nxt;
      blink_q  <= blink_nxt;
      period_q <= period_nxt;
    end
  end

  // period_nxt lets a restart load the value being written on the same edge
  led_blink_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .period  (period_nxt),
    .restart (period_restart),
    .phase   (phase)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
      ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blink_q;
      ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT]     = phase;
        readdata[STATUS_PERIOD_NZ_BIT] = |period_q;
      end
      default:       readdata = '0;
    endcase
  end

  assign out_port = data_q & ~(blink_q & {WIDTH{~phase}});

endmodule

// File: tb/tb_led_blink_pio.sv
// Self-checking bench for led_blink_pio: register vectors plus blink/restart/reset sequences.
module tb_led_blink_pio;

  localparam int          WIDTH = 18;
  localparam int          PW    = 24;
  localparam logic [31:0] RV    = 32'h2AAAA;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [3:0]       byteenable;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  always #5 clk = ~clk;

  led_blink_pio #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PRESCALE_W  (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  typedef struct {
    logic             wr;
    logic [2:0]       waddr;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [2:0]       raddr;
    logic [31:0]      exp_rd;
    logic [WIDTH-1:0] exp_out;
  } vec_t;

  typedef struct {
    logic [31:0]      exp_rd;
    logic [WIDTH-1:0] exp_out;
    int               id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (out_port !== e.exp_out) begin
      n_bad++;
      $display("FAIL out_port[%0d]: got %h expected %h", e.id, out_port, e.exp_out);
    end
    n_cmp++;
    if (readdata !== e.exp_rd) begin
      n_bad++;
      $display("FAIL readdata[%0d] addr %0d: got %h expected %h", e.id, address, readdata, e.exp_rd);
    end
  endtask

  // one bus cycle: optional write, then read raddr after the edge
  task automatic cyc(input logic wr, input logic [2:0] waddr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [2:0] raddr,
                     input logic [31:0] exp_rd, input logic [WIDTH-1:0] exp_out, input int id);
    @(negedge clk);
    chipselect = wr;
    write_n    = ~wr;
    address    = waddr;
    byteenable = be;
    writedata  = wd;
    sb.push_back('{exp_rd, exp_out, id});
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = raddr;
    #1;
    check_pop();
  endtask

  function automatic logic [WIDTH-1:0] blink_out(input logic ph);
    return ph ? 18'h3FFFF : 18'h3FFF0;
  endfunction

  function automatic logic [31:0] status_exp(input logic ph);
    return {30'd0, 1'b1, ph};
  endfunction

  initial begin
    logic ph;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    byteenable = '0; writedata = '0;

    //            wr    waddr be       wdata          raddr exp_rd          exp_out
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd3, 32'h1,          18'h2AAAA});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd1, 32'h0,          18'h2AAAA});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd2, 32'h0,          18'h2AAAA});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd0, 32'h2AAAA,      18'h2AAAA});
    vecs.push_back('{1'b1, 3'd0, 4'hF, 32'h0,         3'd0, 32'h0,          18'h00000});
    vecs.push_back('{1'b1, 3'd0, 4'h5, 32'hFFFF_FFFF, 3'd0, 32'h0003_00FF,  18'h300FF});
    vecs.push_back('{1'b1, 3'd0, 4'hF, 32'h0000_00F0, 3'd0, 32'h0000_00F0,  18'h000F0});
    vecs.push_back('{1'b1, 3'd4, 4'hF, 32'h0000_0003, 3'd4, 32'h0,          18'h000F3});
    vecs.push_back('{1'b1, 3'd5, 4'hF, 32'h0000_0030, 3'd5, 32'h0,          18'h000C3});
    vecs.push_back('{1'b1, 3'd6, 4'hF, 32'h0000_0101, 3'd6, 32'h0,          18'h001C2});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd0, 32'h0000_01C2,  18'h001C2});
    vecs.push_back('{1'b1, 3'd4, 4'h0, 32'hFFFF_FFFF, 3'd0, 32'h0000_01C2,  18'h001C2});
    vecs.push_back('{1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF, 3'd3, 32'h1,          18'h001C2});
    vecs.push_back('{1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF, 3'd7, 32'h0,          18'h001C2});
    vecs.push_back('{1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, 3'd1, 32'h0003_FFFF,  18'h001C2});
    vecs.push_back('{1'b1, 3'd1, 4'hC, 32'h0,         3'd1, 32'h0000_FFFF,  18'h001C2});
    vecs.push_back('{1'b1, 3'd1, 4'hF, 32'h0,         3'd1, 32'h0,          18'h001C2});
    vecs.push_back('{1'b1, 3'd2, 4'h1, 32'hFFFF_FFFF, 3'd2, 32'h0000_00FF,  18'h001C2});
    vecs.push_back('{1'b1, 3'd2, 4'hE, 32'hFFFF_FFFF, 3'd2, 32'h00FF_FFFF,  18'h001C2});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd3, 32'h3,          18'h001C2});
    vecs.push_back('{1'b1, 3'd2, 4'hF, 32'h0,         3'd2, 32'h0,          18'h001C2});
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         3'd3, 32'h1,          18'h001C2});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i])
      cyc(vecs[i].wr, vecs[i].waddr, vecs[i].be, vecs[i].wdata,
          vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_out, i);

    // blink: PERIOD=3 gives 4 cycles on, 4 cycles off on the low nibble
    cyc(1'b1, 3'd0, 4'hF, 32'h3FFFF, 3'd0, 32'h3FFFF, 18'h3FFFF, 100);
    cyc(1'b1, 3'd1, 4'hF, 32'h0000F, 3'd1, 32'h0000F, 18'h3FFFF, 101);
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2) == 0;
      cyc(k == 0, 3'd2, 4'hF, 32'd3, 3'd3, status_exp(ph), blink_out(ph), 200 + k);
    end

    // PERIOD rewrite on the expiry edge: restart wins, no toggle
    for (int j = 0; j <= 16; j++) begin
      ph = (j < 4) ? 1'b1 : ((((j - 4) / 4) % 2) == 0);
      cyc((j == 0) || (j == 4), 3'd2, 4'hF, 32'd3, 3'd3, status_exp(ph), blink_out(ph), 300 + j);
    end

    // reset mid-blink (phase currently 0)
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{32'h0, 18'h2AAAA, 400});
    @(posedge clk);
    #1 reset = 1'b0;
    address = 3'd2;
    #1 check_pop();
    for (int k = 0; k < 10; k++)
      cyc(1'b0, 3'd0, 4'h0, 32'h0, 3'd3, 32'h1, 18'h2AAAA, 401 + k);
    cyc(1'b0, 3'd0, 4'h0, 32'h0, 3'd1, 32'h0, 18'h2AAAA, 411);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
